// File: rtl/bit_align_link_ctrl_if.sv
// Aligner-facing bundle of bit_align_link_ctrl: lock status in, realign request and shadowed thresholds out.
interface bit_align_link_ctrl_if;
    logic        i_bit_locked;
    logic        o_realign_req;
    logic [5:0]  o_cfg_err_th;
    logic [7:0]  o_cfg_verify_cnt_max;
    logic [15:0] o_cfg_lock_loss_to;

    modport master (
        input  i_bit_locked,
        output o_realign_req, o_cfg_err_th, o_cfg_verify_cnt_max, o_cfg_lock_loss_to
    );

    modport slave (
        output i_bit_locked,
        input  o_realign_req, o_cfg_err_th, o_cfg_verify_cnt_max, o_cfg_lock_loss_to
    );
endinterface

// File: rtl/bit_align_link_ctrl.sv
// Bring-up/recovery sequencer for a GT RX bit aligner: shadowed config, acquisition timeout, bounded realign retries.
// Optional ALIGN_CTRL_GT_RESET_EN: FAILSAFE pulses o_rx_reset_req and restarts bring-up instead of halting.
module bit_align_link_ctrl #(
    parameter int ACQ_TIMEOUT = 4096,
    parameter int UP_HOLD     = 256,
    parameter int REQ_LEN     = 8,
    parameter int BACKOFF     = 64,
    parameter int MAX_RETRY   = 7,
    parameter int RST_LEN     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx_reset_done,
    input  logic                        rx_cdr_stable,
    bit_align_link_ctrl_if.master       aln,
    input  logic                        i_sw_realign,
    input  logic [5:0]                  i_cfg_err_th,
    input  logic [7:0]                  i_cfg_verify_cnt_max,
    input  logic [15:0]                 i_cfg_lock_loss_to,
    output logic                        o_link_up,
    output logic                        o_fail,
    output logic [3:0]                  o_retry_cnt,
    output logic [15:0]                 o_loss_cnt,
`ifdef ALIGN_CTRL_GT_RESET_EN
    output logic                        o_rx_reset_req,
`endif
    output logic [2:0]                  o_state
);

    typedef enum logic [2:0] {
        WAIT_RDY = 3'd0,
        ACQUIRE  = 3'd1,
        QUALIFY  = 3'd2,
        UP       = 3'd3,
        REALIGN  = 3'd4,
        BACKOFF_ST = 3'd5,
        FAILSAFE = 3'd6
    } state_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared timer serves every timed state; it restarts on each state change.
    localparam int TMR_LIM = imax(imax(imax(ACQ_TIMEOUT, UP_HOLD), imax(REQ_LEN, BACKOFF)), RST_LEN);
    localparam int TMR_W   = $clog2(TMR_LIM + 1);

    function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] t);
        return (t == '1) ? t : t + 1'b1;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] c);
        return (c == 4'hF) ? c : c + 4'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    function automatic logic [5:0] san_err_th(input logic [5:0] v);
        return (v > 6'd16) ? 6'd16 : v;
    endfunction

    function automatic logic [7:0] san_verify(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

    function automatic logic [15:0] san_lock_to(input logic [15:0] v);
        return (v < 16'd2) ? 16'd2 : v;
    endfunction

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [3:0]       retry_nxt;
    logic [15:0]      loss_nxt;
    logic             fail_nxt, req_nxt, up_nxt, load_cfg;
    logic             sw_q, sw_edge, ready;
`ifdef ALIGN_CTRL_GT_RESET_EN
    logic             rst_req_nxt;
`endif

    assign ready   = rx_reset_done & rx_cdr_stable;
    assign sw_edge = i_sw_realign & ~sw_q;
    assign o_state = state;

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr_inc(tmr);
        retry_nxt = o_retry_cnt;
        loss_nxt  = o_loss_cnt;
        fail_nxt  = o_fail;
        req_nxt   = 1'b0;
        load_cfg  = 1'b0;
`ifdef ALIGN_CTRL_GT_RESET_EN
        rst_req_nxt = 1'b0;
`endif
        if (state != WAIT_RDY && !ready) begin
            state_nxt = WAIT_RDY;
            retry_nxt = 4'd0;
        end else begin
            case (state)
                WAIT_RDY: begin
                    load_cfg = 1'b1;
                    if (ready) state_nxt = ACQUIRE;
                end
                ACQUIRE: begin
                    if (sw_edge) begin
                        state_nxt = REALIGN;
                        retry_nxt = 4'd0;
                    end else if (aln.i_bit_locked) begin
                        state_nxt = QUALIFY;
                    end else if (tmr == TMR_W'(ACQ_TIMEOUT - 1)) begin
                        state_nxt = REALIGN;
                    end
                end
                QUALIFY: begin
                    if (sw_edge) begin
                        state_nxt = REALIGN;
                        retry_nxt = 4'd0;
                    end else if (!aln.i_bit_locked) begin
                        state_nxt = REALIGN;
                    end else if (tmr == TMR_W'(UP_HOLD - 1)) begin
                        state_nxt = UP;
                        retry_nxt = 4'd0;
`ifdef ALIGN_CTRL_GT_RESET_EN
                        fail_nxt  = 1'b0;
`endif
                    end
                end
                UP: begin
                    if (sw_edge) begin
                        state_nxt = REALIGN;
                        retry_nxt = 4'd0;
                    end else if (!aln.i_bit_locked) begin
                        state_nxt = REALIGN;
                        loss_nxt  = sat_inc16(o_loss_cnt);
                    end
                end
                REALIGN: begin
                    load_cfg = 1'b1;
                    if (tmr == '0 && o_retry_cnt == 4'(MAX_RETRY)) begin
                        state_nxt = FAILSAFE;
                        fail_nxt  = 1'b1;
                    end else begin
                        req_nxt = 1'b1;
                        if (tmr == '0) retry_nxt = sat_inc4(o_retry_cnt);
                        if (tmr == TMR_W'(REQ_LEN - 1)) state_nxt = BACKOFF_ST;
                    end
                end
                BACKOFF_ST: begin
                    if (sw_edge) begin
                        state_nxt = REALIGN;
                        retry_nxt = 4'd0;
                    end else if (tmr == TMR_W'(BACKOFF - 1)) begin
                        state_nxt = ACQUIRE;
                    end
                end
                FAILSAFE: begin
                    if (sw_edge) begin
                        state_nxt = REALIGN;
                        retry_nxt = 4'd0;
                        fail_nxt  = 1'b0;
                    end
`ifdef ALIGN_CTRL_GT_RESET_EN
                    else begin
                        rst_req_nxt = 1'b1;
                        if (tmr == TMR_W'(RST_LEN - 1)) begin
                            state_nxt = WAIT_RDY;
                            retry_nxt = 4'd0;
                        end
                    end
`endif
                end
                default: state_nxt = WAIT_RDY;
            endcase
        end
        if (state_nxt != state) tmr_nxt = '0;
        // Link is reported only while staying in UP, so any exit drops it on the same edge.
        up_nxt = (state == UP) && (state_nxt == UP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                    <= WAIT_RDY;
            tmr                      <= '0;
            sw_q                     <= 1'b0;
            o_retry_cnt              <= 4'd0;
            o_loss_cnt               <= 16'd0;
            o_fail                   <= 1'b0;
            o_link_up                <= 1'b0;
            aln.o_realign_req        <= 1'b0;
            aln.o_cfg_err_th         <= 6'd4;
            aln.o_cfg_verify_cnt_max <= 8'd8;
            aln.o_cfg_lock_loss_to   <= 16'd1024;
`ifdef ALIGN_CTRL_GT_RESET_EN
            o_rx_reset_req           <= 1'b0;
`endif
        end else begin
            state             <= state_nxt;
            tmr               <= tmr_nxt;
            sw_q              <= i_sw_realign;
            o_retry_cnt       <= retry_nxt;
            o_loss_cnt        <= loss_nxt;
            o_fail            <= fail_nxt;
            o_link_up         <= up_nxt;
            aln.o_realign_req <= req_nxt;
`ifdef ALIGN_CTRL_GT_RESET_EN
            o_rx_reset_req    <= rst_req_nxt;
`endif
            if (load_cfg) begin
                aln.o_cfg_err_th         <= san_err_th(i_cfg_err_th);
                aln.o_cfg_verify_cnt_max <= san_verify(i_cfg_verify_cnt_max);
                aln.o_cfg_lock_loss_to   <= san_lock_to(i_cfg_lock_loss_to);
            end
        end
    end

endmodule
